// File: rtl/axi_packet_pkg.sv
// axi_packet_pkg
//   Shared types for the axi_packet write slave:
//   - state_e  : write-channel FSM states (IDLE -> DATA -> RESP)
//   - resp_e   : AXI write response encodings
//   - access_e : what a W beat does to storage (nothing, write, or dropped)
//   - address arithmetic constants used when checking a burst's byte range
package axi_packet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  // ACC_DROP is a beat that was handshaken but belongs to an errored burst,
  // so it is consumed without touching storage.
  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_DROP  = 2'd2
  } access_e;

  // Bytes per storage word used for the range check and word indexing.
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_SHIFT     = 2;

  // Extra bits on top of the byte address so that
  // start + (len+1) << size (len up to 255, size up to 7) cannot wrap.
  localparam int unsigned ADDR_EXT_BITS  = 9;

endpackage

// File: rtl/axi_word_ram.sv
// axi_word_ram
//   MEMORY_DEPTH x DATA_WIDTH word storage, no reset (contents persist).
//   Ports:
//     i_clk    : clock, write on rising edge
//     i_we     : write enable
//     i_waddr  : write word index
//     i_wdata  : write data
//     i_raddr  : combinational read word index
//     o_rdata  : combinational read data
module axi_word_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024,
  localparam int IDX_W       = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_packet.sv
// axi_packet
//   AXI4 INCR-only write slave backed by axi_word_ram.
//   One burst at a time: IDLE (accept AW) -> DATA (accept AWLEN+1 beats)
//   -> RESP (hold B until BREADY) -> IDLE.
//   Ports:
//     ACLK, ARESET            : clock, synchronous active-high reset
//     AWADDR/AWLEN/AWSIZE     : burst start byte address, beats-1, log2 bytes/beat
//     AWVALID/AWREADY         : address handshake
//     WDATA/WVALID/WLAST      : write data beat, final-beat marker
//     WREADY                  : data accepted
//     BRESP/BVALID/BREADY     : write response (OKAY or SLVERR only)
module axi_packet
  import axi_packet_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  input  logic                  WLAST,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY
);

  localparam int EXT_W    = ADDR_WIDTH + ADDR_EXT_BITS;
  localparam int IDX_W    = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [EXT_W-1:0] MEM_BYTES = EXT_W'(MEMORY_DEPTH * BYTES_PER_WORD);

  state_e            r_state;
  state_e            w_nxt;
  logic [EXT_W-1:0]  r_cur_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_beat;
  logic [2:0]        r_size;
  logic              r_err;       // range/size error latched at AW time
  logic              r_last_err;  // WLAST protocol violation seen so far
  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  resp_e             r_bresp;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_last_beat;
  logic              w_wlast_bad;
  logic              w_bad_size;
  logic [EXT_W-1:0]  w_end_addr;
  logic              w_aw_err;
  logic [EXT_W-1:0]  w_step;
  logic [IDX_W-1:0]  w_idx;
  access_e           w_acc;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic              w_unused_rd;

  assign w_aw_hs = AWVALID && r_awready;
  assign w_w_hs  = WVALID  && r_wready;
  assign w_b_hs  = BREADY  && r_bvalid;

  // Range check on the widened address so a burst near the top of the
  // AWADDR space is flagged rather than wrapping back into range.
  assign w_bad_size = AWSIZE > 3'(MAX_SIZE);
  assign w_end_addr = EXT_W'(AWADDR) + ((EXT_W'(AWLEN) + EXT_W'(1)) << AWSIZE);
  assign w_aw_err   = w_bad_size || (w_end_addr > MEM_BYTES);

  assign w_step      = EXT_W'(1) << r_size;
  assign w_idx       = IDX_W'(r_cur_addr >> WORD_SHIFT);
  assign w_last_beat = (r_beat == r_len);
  // WLAST must be high exactly on the beat where the counter reaches AWLEN.
  assign w_wlast_bad = w_w_hs && (WLAST != w_last_beat);

  always_comb begin
    w_acc = ACC_NONE;
    if (w_w_hs) w_acc = r_err ? ACC_DROP : ACC_WRITE;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_aw_hs)                w_nxt = ST_DATA;
      ST_DATA: if (w_w_hs && w_last_beat)  w_nxt = ST_RESP;
      ST_RESP: if (w_b_hs)                 w_nxt = ST_IDLE;
      default:                             w_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up
  // with r_state every cycle except the first one after reset, where
  // AWREADY is still held low.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= ST_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_cur_addr <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_beat     <= '0;
      r_err      <= 1'b0;
      r_last_err <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_awready <= (w_nxt == ST_IDLE);
      r_wready  <= (w_nxt == ST_DATA);
      r_bvalid  <= (w_nxt == ST_RESP);

      if (w_aw_hs) begin
        r_cur_addr <= EXT_W'(AWADDR);
        r_len      <= AWLEN;
        r_size     <= AWSIZE;
        r_beat     <= '0;
        r_err      <= w_aw_err;
        r_last_err <= 1'b0;
      end

      if (w_w_hs) begin
        r_cur_addr <= r_cur_addr + w_step;
        r_beat     <= r_beat + 8'd1;
        if (w_wlast_bad) r_last_err <= 1'b1;
        // Response is settled on the final beat and then held for all of RESP.
        if (w_last_beat)
          r_bresp <= (r_err || r_last_err || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  axi_word_ram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH)
  ) u_ram (
    .i_clk   (ACLK),
    .i_we    (w_acc == ACC_WRITE),
    .i_waddr (w_idx),
    .i_wdata (WDATA),
    .i_raddr (w_idx),
    .o_rdata (w_rd_data)
  );

  // The read port exists for inspection of the array; nothing in the
  // write path consumes it.
  assign w_unused_rd = ^w_rd_data;

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;

endmodule

// File: tb/tb_axi_packet.sv
module tb_axi_packet;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] AWADDR = '0;
  logic [7:0]    AWLEN = '0;
  logic [2:0]    AWSIZE = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic          WVALID = 1'b0;
  logic          WLAST = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_packet #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int w_hs_cnt = 0;

  // Reference storage: expected word value and whether it has ever been written.
  logic [31:0] mem_m [DEPTH];
  bit          mem_v [DEPTH];

  always @(posedge ACLK) if (WVALID && WREADY) w_hs_cnt <= w_hs_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // which: 0 = AWREADY, 1 = WREADY
  task automatic wait_rdy(input string tag, input int which, output bit ok);
    int cyc;
    cyc = 0;
    while (((which == 0) ? AWREADY : WREADY) !== 1'b1 && cyc < 32) begin
      tick();
      cyc++;
    end
    ok = (cyc < 32);
    n_cmp++;
    assert (cyc < 32) else begin
      n_bad++;
      $error("FAIL %s_ready_timeout: observed %0d cycles expected < 32", tag, cyc);
    end
  endtask

  task automatic check_mem(input string tag);
    int nm;
    nm = 0;
    for (int k = 0; k < DEPTH; k++)
      if (mem_v[k] && dut.u_ram.r_mem[k] !== mem_m[k]) nm++;
    check({tag, "_mem"}, 64'(nm), 64'(0));
  endtask

  // lmode: 0 = WLAST correct, 1 = WLAST never asserted, 2 = WLAST also on beat 'early'
  task automatic burst(input string tag, input int addr, input int len, input int size,
                       input int lmode, input int early, input int bdly, input bit gaps,
                       input bit seq, input logic [31:0] d0);
    logic [31:0] data [256];
    bit          err;
    logic [1:0]  exp_resp;
    int          c0;
    bit          ok;
    for (int i = 0; i <= len; i++) data[i] = seq ? d0 + 32'(i) : $urandom;
    err = (size > 2) ||
          (longint'(addr) + longint'(len + 1) * (longint'(1) << size) > longint'(DEPTH * 4));
    exp_resp = (err || lmode != 0) ? 2'b10 : 2'b00;
    if (!err) begin
      for (int i = 0; i <= len; i++) begin
        int a;
        a = addr + (i << size);
        mem_m[a / 4] = data[i];
        mem_v[a / 4] = 1'b1;
      end
    end

    c0 = w_hs_cnt;
    AWADDR = AW'(addr); AWLEN = 8'(len); AWSIZE = 3'(size); AWVALID = 1'b1;
    wait_rdy(tag, 0, ok);
    if (!ok) begin AWVALID = 1'b0; return; end
    tick();
    AWVALID = 1'b0;

    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        WVALID = 1'b0;
        tick();
      end
      WDATA  = data[i];
      WLAST  = (lmode == 0) ? (i == len) : (lmode == 1) ? 1'b0 : ((i == early) || (i == len));
      WVALID = 1'b1;
      wait_rdy(tag, 1, ok);
      if (!ok) begin WVALID = 1'b0; return; end
      tick();
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;

    check({tag, "_bvalid_wready"}, 64'({BVALID, WREADY}), 64'(2'b10));
    check({tag, "_bresp"}, 64'(BRESP), 64'(exp_resp));
    check({tag, "_wbeats"}, 64'(w_hs_cnt - c0), 64'(len + 1));
    for (int k = 0; k < bdly; k++) begin
      tick();
      check({tag, "_bhold"}, 64'({BVALID, BRESP}), 64'({1'b1, exp_resp}));
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check({tag, "_bdone"}, 64'({BVALID, AWREADY}), 64'(2'b01));
    check_mem(tag);
  endtask

  initial begin
    int len, size, addr, lm, early;
    logic [31:0] d;
    bit ok;

    // Reset state
    ARESET = 1'b1;
    repeat (3) tick();
    check("rst_outputs", 64'({AWREADY, WREADY, BVALID, BRESP}), 64'(5'b0));
    ARESET = 1'b0;
    tick();
    check("rst_awready_rise", 64'({AWREADY, WREADY, BVALID}), 64'(3'b100));

    // Single beat to word 0
    burst("single", 'h0000, 0, 2, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    check("single_word0", 64'(dut.u_ram.r_mem[0]), 64'(32'hDEADBEEF));

    // Four-beat INCR burst
    burst("incr4", 'h0010, 3, 2, 0, 0, 1, 0, 1, 32'd1);
    for (int k = 0; k < 4; k++)
      check($sformatf("incr4_word%0d", 4 + k), 64'(dut.u_ram.r_mem[4 + k]), 64'(k + 1));

    // Seed the last word, then hit the top-of-memory boundaries
    burst("top_word", 'h0FFC, 0, 2, 0, 0, 0, 0, 1, 32'hA5A51023);
    burst("oor", 'h1000, 1, 2, 0, 0, 0, 0, 0, 32'h0);
    burst("cross", 'h0FFC, 1, 2, 0, 0, 0, 0, 0, 32'h0);
    check("cross_word1023", 64'(dut.u_ram.r_mem[1023]), 64'(32'hA5A51023));
    burst("wrap16", 'hFFFC, 1, 2, 0, 0, 0, 0, 0, 32'h0);
    burst("badsize", 'h0020, 1, 3, 0, 0, 0, 0, 0, 32'h0);

    // WLAST violations; B held for 5 cycles before BREADY
    burst("nolast", 'h0040, 2, 2, 1, 0, 5, 0, 0, 32'h0);
    burst("early", 'h0060, 3, 2, 2, 1, 2, 1, 0, 32'h0);

    // Sub-word beats write the whole word at the beat's word index
    burst("size0", 'h0081, 3, 0, 0, 0, 0, 1, 0, 32'h0);
    burst("size1", 'h0102, 2, 1, 0, 0, 0, 0, 0, 32'h0);

    // Reset after 1 of 4 beats
    AWADDR = AW'(16'h0100); AWLEN = 8'd3; AWSIZE = 3'd2; AWVALID = 1'b1;
    wait_rdy("rstmid", 0, ok);
    tick();
    AWVALID = 1'b0;
    d = $urandom;
    WDATA = d; WLAST = 1'b0; WVALID = 1'b1;
    check("rstmid_wready", 64'(WREADY), 64'(1));
    tick();
    WVALID = 1'b0;
    mem_m['h40] = d; mem_v['h40] = 1'b1;
    ARESET = 1'b1;
    tick();
    check("rstmid_in_reset", 64'({AWREADY, WREADY, BVALID, BRESP}), 64'(5'b0));
    ARESET = 1'b0;
    tick();
    check("rstmid_release", 64'({AWREADY, WREADY, BVALID}), 64'(3'b100));
    check_mem("rstmid");
    burst("post_rst", 'h0200, 0, 2, 0, 0, 1, 0, 0, 32'h0);

    // Randomized bursts against the reference model
    for (int t = 0; t < 40; t++) begin
      len  = int'($urandom_range(0, 7));
      size = int'($urandom_range(0, 3));
      addr = int'($urandom_range(0, 4200));
      lm   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (lm == 2 && len == 0) lm = 1;
      early = (lm == 2) ? int'($urandom_range(0, len - 1)) : 0;
      burst($sformatf("rnd%0d", t), addr, len, size, lm, early,
            int'($urandom_range(0, 3)), 1'b1, 1'b0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_packet.md
AXI_PACKET -- requirements
Module: axi_packet

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width and memory word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the byte-address width.
REQ-003 The block SHALL have parameter MEMORY_DEPTH, default 1024, meaning the number of DATA_WIDTH words of storage.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The ports SHALL be, in order (name, direction, width, meaning):
- ACLK, in, 1, clock; all logic on rising edge.
- ARESET, in, 1, synchronous active-high reset.
- AWADDR, in, ADDR_WIDTH, burst start byte address.
- AWLEN, in, 8, beats minus 1.
- AWSIZE, in, 3, log2 of bytes per beat.
- AWVALID, in, 1, address valid.
- AWREADY, out, 1, address accepted.
- WDATA, in, DATA_WIDTH, write data.
- WVALID, in, 1, data valid.
- WLAST, in, 1, final beat marker.
- WREADY, out, 1, data accepted.
- BRESP, out, 2, write response.
- BVALID, out, 1, response valid.
- BREADY, in, 1, response accepted.

Function
REQ-006 The block SHALL implement an AXI4 INCR-only write slave with a three-state FSM: IDLE -> DATA -> RESP -> IDLE.
REQ-007 In IDLE, AWREADY SHALL be 1 and WREADY and BVALID SHALL be 0; an AW handshake (AWVALID&&AWREADY) SHALL latch AWADDR/AWLEN/AWSIZE, clear the beat counter, and enter DATA next cycle.
REQ-008 On AW acceptance the block SHALL compute the error flag:
- error=1 if AWSIZE > log2(DATA_WIDTH/8).
- error=1 if AWADDR + (AWLEN+1)*2^AWSIZE > MEMORY_DEPTH*4.
- error=0 otherwise.
- All arithmetic SHALL be at least ADDR_WIDTH+9 bits wide, so the end-address sum cannot overflow.
REQ-009 In DATA, WREADY SHALL be 1 and AWREADY 0; WREADY SHALL stay high for the whole data phase.
REQ-010 Each W handshake SHALL do the following:
- If error=0, write WDATA to word index (current address >> 2).
- Advance the current address by 2^AWSIZE.
- Increment the beat counter.
REQ-011 Sub-word AWSIZE (0, 1) writes SHALL write the whole WDATA word at the word index (no byte strobes).
REQ-012 DATA SHALL end on the handshake where the beat counter equals AWLEN.
REQ-013 If WLAST on that final beat is 0, or WLAST is 1 on any earlier beat, the response SHALL be SLVERR; writes still SHALL occur for in-range beats; W beats arriving after an early WLAST SHALL still be consumed up to AWLEN+1.
REQ-014 In RESP, BVALID SHALL be 1 starting the cycle after the final W handshake; BRESP SHALL be OKAY (2'b00) if no error, else SLVERR (2'b10).
REQ-015 BRESP SHALL hold stable while BVALID=1; the B handshake (BVALID&&BREADY) SHALL return to IDLE next cycle with BVALID=0.
REQ-016 EXOKAY (01) and DECERR (11) SHALL never be produced.
REQ-017 An out-of-range or bad-size burst SHALL never modify memory.
REQ-018 Memory contents SHALL persist across bursts.

Reset
REQ-019 On ARESET=1 at a rising edge, the block SHALL enter IDLE and drive AWREADY=0, WREADY=0, BVALID=0, BRESP=2'b00; AWREADY SHALL rise the first cycle after ARESET deasserts.
REQ-020 Reset mid-burst SHALL abandon the burst without a response; memory contents are not cleared by reset.

Structure
REQ-021 A shared package SHALL hold the state enum (IDLE, DATA, RESP), the response enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), and the access enum.
REQ-022 Storage SHALL be a single sub-module axi_word_ram: MEMORY_DEPTH x DATA_WIDTH, one synchronous write port, one combinational read port for verification access.

Verification
REQ-023 Bench scenarios (stimulus -> required response):
- AWADDR=0x0000, AWLEN=0, AWSIZE=2, WDATA=0xDEADBEEF, WLAST=1 -> BRESP=00; word 0 = 0xDEADBEEF.
- AWADDR=0x0010, AWLEN=3, AWSIZE=2, data 1,2,3,4 -> BRESP=00; words 4..7 = 1..4; exactly 4 W handshakes.
- AWADDR=0x1000 (=MEMORY_DEPTH*4), AWLEN=1 -> BRESP=10; memory unchanged.
- AWADDR=0x0FFC, AWLEN=1, AWSIZE=2 (crosses end) -> BRESP=10; word 1023 unchanged.
- AWLEN=2, WLAST=0 on beat 2 -> BRESP=10; BVALID held until BREADY asserted 5 cycles later.
- ARESET asserted after 1 of 4 beats -> BVALID=0, AWREADY=1 one cycle after release; next single-beat write -> BRESP=00.
